// File: rtl/axi_mtimer_slave.sv
// axi_mtimer_slave: AXI4 single-beat responder for a RISC-V machine timer
// (64-bit mtime/mtimecmp, prescaler/enable control, level timer interrupt).
`default_nettype none

package axi_mtimer_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
  } s_axi_miso_t;
endpackage

module axi_mtimer_slave
  import axi_mtimer_pkg::*;
#(
  parameter logic [15:0] PRESC_RST = 16'd0,
  parameter logic        EN_RST    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  s_axi_mosi_t axi_mosi,
  output s_axi_miso_t axi_miso,
  output logic        timer_irq_o
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  wstate_t     r_wstate, w_wstate_nxt;
  rstate_t     r_rstate, w_rstate_nxt;

  logic [2:0]  r_awoff;
  logic [3:0]  r_awid;
  logic [7:0]  r_awlen;
  logic [3:0]  r_arid;
  logic [7:0]  r_arlen;
  logic [7:0]  r_beat;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;

  logic [63:0] r_mtime, w_mtime_nxt;
  logic [63:0] r_mtimecmp, w_cmp_nxt;
  logic        r_en, w_en_nxt;
  logic [15:0] r_presc, w_presc_nxt;
  logic [15:0] r_psc, w_psc_nxt;
  logic        r_irq;

  logic        w_awready, w_wready, w_arready;
  logic        w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
  logic        w_rlast;
  logic        w_wmapped, w_wr_en, w_tick;
  logic        w_wr_mtlo, w_wr_mthi, w_wr_cmplo, w_wr_cmphi, w_wr_ctrl;
  logic [31:0] w_wmask;
  logic [31:0] w_rd_val;
  logic        w_rd_map;
  logic        w_unused;

  assign w_unused = ^{axi_mosi.awaddr[31:5], axi_mosi.awaddr[1:0],
                      axi_mosi.araddr[31:5], axi_mosi.araddr[1:0]};

  assign w_awready = (r_wstate == W_IDLE) && !rst;
  assign w_wready  = (r_wstate == W_DATA) && !rst;
  assign w_arready = (r_rstate == R_IDLE) && !rst;
  assign w_aw_hs   = w_awready && axi_mosi.awvalid;
  assign w_w_hs    = w_wready && axi_mosi.wvalid;
  assign w_ar_hs   = w_arready && axi_mosi.arvalid;
  assign w_rlast   = (r_rstate == R_DATA) && (r_beat == r_arlen);
  assign w_r_hs    = (r_rstate == R_DATA) && axi_mosi.rready;

  // Write path
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_hs && axi_mosi.wlast) w_wstate_nxt = W_RESP;
      W_RESP:  if (axi_mosi.bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Read path
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (w_r_hs && w_rlast) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  assign w_wmapped  = (r_awoff <= 3'd4);
  assign w_wr_en    = w_w_hs && (r_awlen == 8'd0) && w_wmapped;
  assign w_wr_mtlo  = w_wr_en && (r_awoff == 3'd0);
  assign w_wr_mthi  = w_wr_en && (r_awoff == 3'd1);
  assign w_wr_cmplo = w_wr_en && (r_awoff == 3'd2);
  assign w_wr_cmphi = w_wr_en && (r_awoff == 3'd3);
  assign w_wr_ctrl  = w_wr_en && (r_awoff == 3'd4);
  assign w_wmask    = {{8{axi_mosi.wstrb[3]}}, {8{axi_mosi.wstrb[2]}},
                       {8{axi_mosi.wstrb[1]}}, {8{axi_mosi.wstrb[0]}}};

  // >= rather than == so lowering presc below the running count cannot stall mtime
  assign w_tick    = r_en && (r_psc >= r_presc);
  assign w_psc_nxt = !r_en ? r_psc : (w_tick ? 16'd0 : r_psc + 16'd1);

  // A bus write to mtime suppresses that cycle's increment entirely (no partial carry)
  always_comb begin
    w_mtime_nxt = r_mtime;
    if (w_wr_mtlo)
      w_mtime_nxt[31:0] = (r_mtime[31:0] & ~w_wmask) | (axi_mosi.wdata & w_wmask);
    else if (w_wr_mthi)
      w_mtime_nxt[63:32] = (r_mtime[63:32] & ~w_wmask) | (axi_mosi.wdata & w_wmask);
    else if (w_tick)
      w_mtime_nxt = r_mtime + 64'd1;
  end

  always_comb begin
    w_cmp_nxt = r_mtimecmp;
    if (w_wr_cmplo)
      w_cmp_nxt[31:0] = (r_mtimecmp[31:0] & ~w_wmask) | (axi_mosi.wdata & w_wmask);
    else if (w_wr_cmphi)
      w_cmp_nxt[63:32] = (r_mtimecmp[63:32] & ~w_wmask) | (axi_mosi.wdata & w_wmask);
  end

  always_comb begin
    w_en_nxt    = r_en;
    w_presc_nxt = r_presc;
    if (w_wr_ctrl) begin
      if (axi_mosi.wstrb[0]) w_en_nxt = axi_mosi.wdata[0];
      if (axi_mosi.wstrb[2]) w_presc_nxt[7:0]  = axi_mosi.wdata[23:16];
      if (axi_mosi.wstrb[3]) w_presc_nxt[15:8] = axi_mosi.wdata[31:24];
    end
  end

  always_comb begin
    w_rd_val = 32'd0;
    w_rd_map = 1'b1;
    case (axi_mosi.araddr[4:2])
      3'd0:    w_rd_val = r_mtime[31:0];
      3'd1:    w_rd_val = r_mtime[63:32];
      3'd2:    w_rd_val = r_mtimecmp[31:0];
      3'd3:    w_rd_val = r_mtimecmp[63:32];
      3'd4:    w_rd_val = {r_presc, 15'd0, r_en};
      default: w_rd_map = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate   <= W_IDLE;
      r_rstate   <= R_IDLE;
      r_awoff    <= 3'd0;
      r_awid     <= 4'd0;
      r_awlen    <= 8'd0;
      r_arid     <= 4'd0;
      r_arlen    <= 8'd0;
      r_beat     <= 8'd0;
      r_rdata    <= 32'd0;
      r_rresp    <= RESP_OKAY;
      r_mtime    <= 64'd0;
      r_mtimecmp <= '1;
      r_en       <= EN_RST;
      r_presc    <= PRESC_RST;
      r_psc      <= 16'd0;
      r_irq      <= 1'b0;
    end else begin
      r_wstate   <= w_wstate_nxt;
      r_rstate   <= w_rstate_nxt;
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_cmp_nxt;
      r_en       <= w_en_nxt;
      r_presc    <= w_presc_nxt;
      r_psc      <= w_psc_nxt;
      r_irq      <= (w_mtime_nxt >= w_cmp_nxt);
      if (w_aw_hs) begin
        r_awoff <= axi_mosi.awaddr[4:2];
        r_awid  <= axi_mosi.awid;
        r_awlen <= axi_mosi.awlen;
      end
      // Read data is sampled from pre-write register values on the AR handshake
      if (w_ar_hs) begin
        r_arid  <= axi_mosi.arid;
        r_arlen <= axi_mosi.arlen;
        r_beat  <= 8'd0;
        if (axi_mosi.arlen == 8'd0 && w_rd_map) begin
          r_rdata <= w_rd_val;
          r_rresp <= RESP_OKAY;
        end else begin
          r_rdata <= 32'd0;
          r_rresp <= RESP_SLVERR;
        end
      end else if (w_r_hs && !w_rlast) begin
        r_beat <= r_beat + 8'd1;
      end
    end
  end

  always_comb begin
    axi_miso         = '0;
    axi_miso.awready = w_awready;
    axi_miso.wready  = w_wready;
    axi_miso.arready = w_arready;
    axi_miso.bvalid  = (r_wstate == W_RESP);
    axi_miso.bid     = r_awid;
    axi_miso.bresp   = ((r_awlen == 8'd0) && w_wmapped) ? RESP_OKAY : RESP_SLVERR;
    axi_miso.rvalid  = (r_rstate == R_DATA);
    axi_miso.rid     = r_arid;
    axi_miso.rdata   = r_rdata;
    axi_miso.rresp   = r_rresp;
    axi_miso.rlast   = w_rlast;
  end

  assign timer_irq_o = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_axi_mtimer_slave.sv
// Directed bench for axi_mtimer_slave; B/R expectations go through scoreboard queues.
`default_nettype none

module tb_axi_mtimer_slave;
  import axi_mtimer_pkg::*;

  localparam logic [15:0] TB_PRESC = 16'h0005;
  localparam logic        TB_EN    = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;
  logic        irq;

  int tests = 0;
  int fails = 0;

  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rexp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
  rexp_t rq[$];
  bexp_t bq[$];
  logic  irq_after_w;

  axi_mtimer_slave #(.PRESC_RST(TB_PRESC), .EN_RST(TB_EN)) dut (
    .clk        (clk),
    .rst        (rst),
    .axi_mosi   (mosi),
    .axi_miso   (miso),
    .timer_irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [3:0] id,
                           input logic [7:0] len, input logic [1:0] eresp, input string tag);
    int    n;
    bexp_t e;
    e.id = id; e.resp = eresp;
    bq.push_back(e);
    mosi.awvalid = 1'b1; mosi.awaddr = addr; mosi.awid = id; mosi.awlen = len;
    n = 0;
    while (!miso.awready && n < 20) begin tick(); n++; end
    if (n >= 20) chk({tag, " awready timeout"}, miso.awready, 1);
    tick();
    mosi.awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      mosi.wvalid = 1'b1; mosi.wdata = data; mosi.wstrb = strb; mosi.wlast = (b == int'(len));
      n = 0;
      while (!miso.wready && n < 20) begin tick(); n++; end
      if (n >= 20) chk({tag, " wready timeout"}, miso.wready, 1);
      tick();
    end
    mosi.wvalid = 1'b0; mosi.wlast = 1'b0;
    irq_after_w = irq;
    mosi.bready = 1'b1;
    n = 0;
    while (!miso.bvalid && n < 20) begin tick(); n++; end
    if (n >= 20) chk({tag, " bvalid timeout"}, miso.bvalid, 1);
    else begin
      e = bq.pop_front();
      chk({tag, " bid"}, miso.bid, e.id);
      chk({tag, " bresp"}, miso.bresp, e.resp);
    end
    tick();
    mosi.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input bit toggle, input bit check, input logic [31:0] edata,
                          input logic [1:0] eresp, input string tag, output logic [31:0] got);
    int    n;
    int    b;
    rexp_t e;
    got = 32'd0;
    if (check)
      for (int i = 0; i <= int'(len); i++) begin
        e.id = id; e.data = edata; e.resp = eresp; e.last = (i == int'(len));
        rq.push_back(e);
      end
    mosi.arvalid = 1'b1; mosi.araddr = addr; mosi.arid = id; mosi.arlen = len;
    n = 0;
    while (!miso.arready && n < 20) begin tick(); n++; end
    if (n >= 20) chk({tag, " arready timeout"}, miso.arready, 1);
    tick();
    mosi.arvalid = 1'b0;
    b = 0; n = 0;
    while (b <= int'(len) && n < 100) begin
      mosi.rready = toggle ? n[0] : 1'b1;
      if (miso.rvalid && mosi.rready) begin
        got = miso.rdata;
        if (check && rq.size() > 0) begin
          e = rq.pop_front();
          chk({tag, " rid"}, miso.rid, e.id);
          chk({tag, " rdata"}, miso.rdata, e.data);
          chk({tag, " rresp"}, miso.rresp, e.resp);
          chk({tag, " rlast"}, miso.rlast, e.last);
        end
        b++;
      end
      tick();
      n++;
    end
    mosi.rready = 1'b0;
    if (b <= int'(len)) chk({tag, " rvalid timeout"}, miso.rvalid, 1);
  endtask

  initial begin
    logic [31:0] d, v1, v2;
    int n;
    mosi = '0;
    rst  = 1'b1;
    repeat (3) tick();
    chk("rst awready", miso.awready, 0);
    chk("rst arready", miso.arready, 0);
    chk("rst bvalid", miso.bvalid, 0);
    chk("rst rvalid", miso.rvalid, 0);
    chk("rst irq", irq, 0);
    rst = 1'b0;
    tick();
    chk("idle awready", miso.awready, 1);
    chk("idle bvalid", miso.bvalid, 0);
    chk("idle irq", irq, 0);

    axi_read(32'h08, 4'd1, 8'd0, 0, 1, 32'hFFFF_FFFF, RESP_OKAY, "cmp_lo rst", d);
    axi_read(32'h0C, 4'd2, 8'd0, 0, 1, 32'hFFFF_FFFF, RESP_OKAY, "cmp_hi rst", d);
    axi_read(32'h10, 4'd3, 8'd0, 0, 1, {TB_PRESC, 15'd0, TB_EN}, RESP_OKAY, "ctrl rst", d);

    axi_write(32'h08, 32'hAABB_CCDD, 4'b0010, 4'd5, 8'd0, RESP_OKAY, "strb wr");
    axi_read(32'h08, 4'd4, 8'd0, 0, 1, 32'hFFFF_CCFF, RESP_OKAY, "strb rd", d);

    // presc=3: 42-ish edges between mtime write and AR capture -> 10 or 11
    axi_write(32'h10, 32'h0003_0001, 4'hF, 4'd1, 8'd0, RESP_OKAY, "ctrl p3");
    axi_write(32'h04, 32'd0, 4'hF, 4'd1, 8'd0, RESP_OKAY, "mt_hi 0");
    axi_write(32'h00, 32'd0, 4'hF, 4'd1, 8'd0, RESP_OKAY, "mt_lo 0");
    repeat (40) tick();
    axi_read(32'h00, 4'd2, 8'd0, 0, 0, 32'd0, RESP_OKAY, "mt run", d);
    chk("mt run range", (d >= 32'd9 && d <= 32'd12), 1);

    axi_write(32'h10, 32'h0003_0000, 4'hF, 4'd1, 8'd0, RESP_OKAY, "ctrl dis");
    axi_read(32'h00, 4'd2, 8'd0, 0, 0, 32'd0, RESP_OKAY, "mt frz1", v1);
    repeat (20) tick();
    axi_read(32'h00, 4'd2, 8'd0, 0, 0, 32'd0, RESP_OKAY, "mt frz2", v2);
    chk("mt frozen", v2, v1);

    axi_write(32'h10, 32'h0000_0000, 4'hF, 4'd1, 8'd0, RESP_OKAY, "ctrl p0 off");
    axi_write(32'h04, 32'd0, 4'hF, 4'd1, 8'd0, RESP_OKAY, "carry hi");
    axi_write(32'h00, 32'hFFFF_FFF0, 4'hF, 4'd1, 8'd0, RESP_OKAY, "carry lo");
    axi_write(32'h10, 32'h0000_0001, 4'hF, 4'd1, 8'd0, RESP_OKAY, "ctrl p0 on");
    repeat (20) tick();
    axi_read(32'h04, 4'd6, 8'd0, 0, 1, 32'd1, RESP_OKAY, "carry rd hi", d);
    axi_read(32'h00, 4'd6, 8'd0, 0, 0, 32'd0, RESP_OKAY, "carry rd lo", d);
    chk("carry lo small", (d < 32'h40), 1);

    axi_write(32'h10, 32'h0000_0000, 4'hF, 4'd1, 8'd0, RESP_OKAY, "irq stop");
    axi_write(32'h0C, 32'd0, 4'hF, 4'd1, 8'd0, RESP_OKAY, "irq cmp hi0");
    chk("irq set by cmp lower", irq_after_w, 1);
    axi_write(32'h08, 32'd100, 4'hF, 4'd1, 8'd0, RESP_OKAY, "irq cmp lo");
    axi_write(32'h04, 32'd0, 4'hF, 4'd1, 8'd0, RESP_OKAY, "irq mt hi");
    axi_write(32'h00, 32'd90, 4'hF, 4'd1, 8'd0, RESP_OKAY, "irq mt lo");
    chk("irq low before run", irq, 0);
    axi_write(32'h10, 32'h0000_0001, 4'hF, 4'd1, 8'd0, RESP_OKAY, "irq run");
    n = 0;
    while (!irq && n < 30) begin tick(); n++; end
    chk("irq rise", irq, 1);
    chk("irq latency", (n >= 7 && n <= 11), 1);
    axi_write(32'h0C, 32'd1, 4'hF, 4'd7, 8'd0, RESP_OKAY, "irq cmp hi1");
    chk("irq clear", irq_after_w, 0);
    chk("irq stays clear", irq, 0);

    axi_read(32'h00, 4'd9, 8'd3, 1, 1, 32'd0, RESP_SLVERR, "burst rd", d);
    axi_write(32'h08, 32'h1234_5678, 4'hF, 4'd6, 8'd1, RESP_SLVERR, "burst wr");
    axi_read(32'h08, 4'd3, 8'd0, 0, 1, 32'd100, RESP_OKAY, "after burst wr", d);
    axi_read(32'h18, 4'd8, 8'd0, 0, 1, 32'd0, RESP_SLVERR, "unmapped rd", d);
    axi_write(32'h14, 32'hDEAD_BEEF, 4'hF, 4'd2, 8'd0, RESP_SLVERR, "unmapped wr");
    axi_read(32'h0C, 4'd3, 8'd0, 0, 1, 32'd1, RESP_OKAY, "after unmapped wr", d);

    mosi.arvalid = 1'b1; mosi.araddr = 32'h0; mosi.arlen = 8'd0; mosi.rready = 1'b0;
    tick();
    mosi.arvalid = 1'b0;
    chk("abort rvalid up", miso.rvalid, 1);
    rst = 1'b1;
    tick();
    chk("abort rvalid drop", miso.rvalid, 0);
    rst = 1'b0;
    mosi.rready = 1'b1;
    repeat (3) tick();
    chk("abort no stale R", miso.rvalid, 0);
    mosi.rready = 1'b0;
    axi_read(32'h0C, 4'd4, 8'd0, 0, 1, 32'hFFFF_FFFF, RESP_OKAY, "cmp after rst", d);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
